// File: rtl/intr_timer_if.sv
// Load/store bus and interrupt handshake between the writeback stage
// and intr_timer_ctrl. The master side is the core, the slave side is the block.
interface intr_timer_if #(
    parameter int N_EXT = 3
);
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic           wr;
    logic           rd;
    logic           sel;
    logic [31:0]    rdata;
    logic           irq_ack;
    logic [1:0]     ack_id;
    logic [N_EXT:0] interrupt;

    modport master (
        output addr, wdata, wr, rd, irq_ack, ack_id,
        input  sel, rdata, interrupt
    );

    modport slave (
        input  addr, wdata, wr, rd, irq_ack, ack_id,
        output sel, rdata, interrupt
    );
endinterface

// File: rtl/intr_timer_ctrl.sv
// Interrupt source and machine timer on the writeback load/store bus.
// Edge-latched external lines plus a prescaled 32-bit MTIME/MTIMECMP timer,
// presented to the core as a masked pending vector (bit0 = timer).
// Optional macro IRQ_SYNC_EN: adds a 2-flop synchronizer on every ext line
// (ext-to-interrupt latency becomes 3 edges instead of 1).
module intr_timer_ctrl #(
    parameter int          N_EXT     = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_EXT-1:0] i_ext_irq,
    intr_timer_if.slave      bus
);
    logic [31:0]    r_mtime;
    logic [31:0]    r_mtimecmp;
    logic [15:0]    r_presc;
    logic [15:0]    r_pcnt;
    logic [N_EXT:0] r_en;
    logic [N_EXT:1] r_pend;
    logic [N_EXT-1:0] r_prev;

    logic [31:0]    w_off;
    logic           w_sel;
    logic           w_wr_mtime, w_wr_cmp, w_wr_pend, w_wr_en, w_wr_presc;
    logic           w_tick;
    logic           w_tpend;
    logic [N_EXT-1:0] w_ext;
    logic [N_EXT:1] w_set;
    logic [N_EXT:1] w_clr;

    // Address decode: word-aligned hits in BASE_ADDR..BASE_ADDR+0x13 only
    assign w_off      = bus.addr - BASE_ADDR;
    assign w_sel      = (bus.addr >= BASE_ADDR) && (w_off <= 32'h10) && (bus.addr[1:0] == 2'b00);
    assign w_wr_mtime = bus.wr && w_sel && (w_off[4:2] == 3'd0);
    assign w_wr_cmp   = bus.wr && w_sel && (w_off[4:2] == 3'd1);
    assign w_wr_pend  = bus.wr && w_sel && (w_off[4:2] == 3'd2);
    assign w_wr_en    = bus.wr && w_sel && (w_off[4:2] == 3'd3);
    assign w_wr_presc = bus.wr && w_sel && (w_off[4:2] == 3'd4);
    assign bus.sel    = w_sel;

`ifdef IRQ_SYNC_EN
    logic [N_EXT-1:0] r_sync1;
    logic [N_EXT-1:0] r_sync2;

    // Two-flop synchronizer for asynchronous external lines
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_ext_irq;
            r_sync2 <= r_sync1;
        end
    end
    assign w_ext = r_sync2;
`else
    assign w_ext = i_ext_irq;
`endif

    // Timer advances when the prescale counter reaches its terminal value
    assign w_tick  = (r_pcnt == r_presc);
    // Timer pending is a level compare, never latched
    assign w_tpend = (r_mtime >= r_mtimecmp);

    // Prescale counter; a PRESCALE write restarts the period
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)        r_pcnt <= '0;
        else if (w_wr_presc) r_pcnt <= '0;
        else if (w_tick)     r_pcnt <= '0;
        else                 r_pcnt <= r_pcnt + 16'd1;
    end

    // MTIME: software write overrides the increment in the same cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)        r_mtime <= '0;
        else if (w_wr_mtime) r_mtime <= bus.wdata;
        else if (w_tick)     r_mtime <= r_mtime + 32'd1;
    end

    // Plain RW configuration registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtimecmp <= 32'hFFFF_FFFF;
            r_en       <= '0;
            r_presc    <= '0;
        end else begin
            if (w_wr_cmp)   r_mtimecmp <= bus.wdata;
            if (w_wr_en)    r_en       <= bus.wdata[N_EXT:0];
            if (w_wr_presc) r_presc    <= bus.wdata[15:0];
        end
    end

    // Per-line rising-edge set and ack / W1C clear requests
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int j = 1; j <= N_EXT; j++) begin
            w_set[j] = w_ext[j-1] & ~r_prev[j-1];
            w_clr[j] = (bus.irq_ack && (int'(bus.ack_id) == j)) || (w_wr_pend && bus.wdata[j]);
        end
    end

    // Pending latch: set beats clear so a coincident new edge is kept
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= w_ext;
            r_pend <= w_set | (r_pend & ~w_clr);
        end
    end

    // Interrupt vector is masked pending; forced quiet while in reset
    assign bus.interrupt = i_rst_n ? ({r_pend, w_tpend} & r_en) : '0;

    // Zero-wait-state read mux; returns pre-write register values
    always_comb begin
        bus.rdata = '0;
        if (bus.rd && w_sel && i_rst_n) begin
            case (w_off[4:2])
                3'd0:    bus.rdata = r_mtime;
                3'd1:    bus.rdata = r_mtimecmp;
                3'd2:    bus.rdata = 32'({r_pend, w_tpend});
                3'd3:    bus.rdata = 32'(r_en);
                3'd4:    bus.rdata = {16'h0000, r_presc};
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_intr_timer_ctrl.sv
// Directed bench for intr_timer_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_intr_timer_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] O_MTIME = 32'h00, O_CMP = 32'h04, O_PEND = 32'h08,
                            O_EN = 32'h0C, O_PRESC = 32'h10;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ext;
    int         total = 0;
    int         bad = 0;

    intr_timer_if #(.N_EXT(3)) bus();

    intr_timer_ctrl #(.N_EXT(3), .BASE_ADDR(BASE)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ext_irq (ext),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr32(input logic [31:0] off, input logic [31:0] data);
        bus.addr  = BASE + off;
        bus.wdata = data;
        bus.wr    = 1'b1;
        tick();
        bus.wr    = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus.addr = BASE + off;
        bus.rd   = 1'b1;
        #1;
        d = bus.rdata;
        bus.rd   = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic ack(input logic [1:0] id);
        bus.irq_ack = 1'b1;
        bus.ack_id  = id;
        tick();
        bus.irq_ack = 1'b0;
        bus.ack_id  = 2'd0;
    endtask

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.wr = 1'b0; bus.rd = 1'b0;
        bus.irq_ack = 1'b0; bus.ack_id = 2'd0;
        ext = 3'b000;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // Reset values
        rdchk("rst_mtime", O_MTIME, 32'h0);
        rdchk("rst_cmp",   O_CMP,   32'hFFFF_FFFF);
        rdchk("rst_pend",  O_PEND,  32'h0);
        rdchk("rst_en",    O_EN,    32'h0);
        chk("rst_irq", 32'(bus.interrupt), 32'h0);

        // Timer compare at PRESCALE=0
        wr32(O_EN, 32'h1);
        wr32(O_CMP, 32'd10);
        wr32(O_MTIME, 32'd0);
        tick(9);
        chk("cmp_before", 32'(bus.interrupt), 32'h0);
        rdchk("mtime_9", O_MTIME, 32'd9);
        tick();
        chk("cmp_hit", 32'(bus.interrupt), 32'h1);
        rdchk("mtime_10", O_MTIME, 32'd10);
        ack(2'd0);
        chk("ack0_noeffect", 32'(bus.interrupt), 32'h1);
        wr32(O_CMP, 32'hFFFF_FFFF);
        chk("cmp_drop", 32'(bus.interrupt), 32'h0);

        // Prescaler = 3 : one increment every 4 cycles, then wrap
        wr32(O_PRESC, 32'd3);
        wr32(O_MTIME, 32'd0);
        tick(2);
        rdchk("psc_a", O_MTIME, 32'd0);
        tick();
        rdchk("psc_b", O_MTIME, 32'd1);
        tick(3);
        rdchk("psc_c", O_MTIME, 32'd1);
        tick();
        rdchk("psc_d", O_MTIME, 32'd2);
        wr32(O_MTIME, 32'hFFFF_FFFE);
        tick(2);
        rdchk("wrap_a", O_MTIME, 32'hFFFF_FFFE);
        tick();
        rdchk("wrap_b", O_MTIME, 32'hFFFF_FFFF);
        chk("tmr_at_max", 32'(bus.interrupt), 32'h1);
        tick(4);
        rdchk("wrap_c", O_MTIME, 32'h0);
        chk("tmr_after_wrap", 32'(bus.interrupt), 32'h0);

        // External edge, hold, ack, no retrigger on a held line
        wr32(O_EN, 32'hF);
        ext = 3'b010; tick(); ext = 3'b000;
        tick(LAT - 1);
        chk("ext1_set", 32'(bus.interrupt), 32'h4);
        tick();
        chk("ext1_hold", 32'(bus.interrupt), 32'h4);
        ack(2'd2);
        chk("ext1_ack", 32'(bus.interrupt), 32'h0);
        ext = 3'b010;
        tick(LAT);
        chk("held_set", 32'(bus.interrupt), 32'h4);
        ack(2'd2);
        chk("held_ack", 32'(bus.interrupt), 32'h0);
        tick(LAT + 1);
        chk("held_noretrig", 32'(bus.interrupt), 32'h0);
        ext = 3'b000;
        tick(LAT + 1);

        // Set beats clear on the same edge
        ext = 3'b001; tick(); ext = 3'b000;
        tick(LAT - 1);
        chk("coll_pre", 32'(bus.interrupt), 32'h2);
        tick();
        ext = 3'b001;
        tick(LAT - 1);
        ack(2'd1);
        chk("coll_keep", 32'(bus.interrupt), 32'h2);
        rdchk("coll_pend", O_PEND, 32'h2);
        ext = 3'b000;
        ack(2'd1);
        chk("coll_clr", 32'(bus.interrupt), 32'h0);
        tick(LAT + 1);

        // Masking and W1C
        wr32(O_EN, 32'h0);
        ext = 3'b100; tick(); ext = 3'b000;
        tick(LAT - 1);
        chk("mask_irq", 32'(bus.interrupt), 32'h0);
        rdchk("mask_pend", O_PEND, 32'h8);
        wr32(O_EN, 32'h8);
        chk("unmask_irq", 32'(bus.interrupt), 32'h8);
        wr32(O_PEND, 32'h8);
        chk("w1c_irq", 32'(bus.interrupt), 32'h0);
        rdchk("w1c_pend", O_PEND, 32'h0);

        // Decode boundaries and ignored unaligned write
        bus.addr = BASE + 32'h2;  #1; chk("sel_unal", 32'(bus.sel), 32'h0);
        bus.addr = BASE + 32'h14; #1; chk("sel_past", 32'(bus.sel), 32'h0);
        bus.addr = BASE - 32'h4;  #1; chk("sel_below", 32'(bus.sel), 32'h0);
        bus.addr = BASE + 32'h10; #1; chk("sel_last", 32'(bus.sel), 32'h1);
        wr32(32'h0E, 32'hF);
        rdchk("unal_ignored", O_EN, 32'h8);
        rdchk("rd_oor", 32'h14, 32'h0);

        // Reset mid-operation
        wr32(O_EN, 32'hF);
        wr32(O_PRESC, 32'd5);
        ext = 3'b001; tick(); ext = 3'b000;
        tick(LAT - 1);
        chk("pre_rst_irq", 32'(bus.interrupt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("in_rst_irq", 32'(bus.interrupt), 32'h0);
        rdchk("in_rst_rdata", O_EN, 32'h0);
        tick();
        rst_n = 1'b1;
        rdchk("post_mtime", O_MTIME, 32'h0);
        rdchk("post_cmp",   O_CMP,   32'hFFFF_FFFF);
        rdchk("post_pend",  O_PEND,  32'h0);
        rdchk("post_en",    O_EN,    32'h0);
        rdchk("post_presc", O_PRESC, 32'h0);
        chk("post_irq", 32'(bus.interrupt), 32'h0);
        tick();
        rdchk("post_count", O_MTIME, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
